// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit ALU datapath: opcodes, instruction field
// positions and the sequencer state encoding.
package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Field slices shared with the ALU and the register file
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;

    typedef enum logic [2:0] {
        ST_HALT,
        ST_FETCH,
        ST_DECODE,
        ST_FETCH_N,
        ST_EXEC,
        ST_WB
    } seq_state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier used by the sequencer in its DECODE state.
module alu_seq_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       needs_imm,
    output logic       writes_rd,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        needs_imm  = 1'b0;
        writes_rd  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD:  writes_rd = 1'b1;
            OP_ADDI: begin
                writes_rd = 1'b1;
                needs_imm = 1'b1;
            end
            OP_NOP:  ;
            OP_HLT:  is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the ALU datapath: fetches instruction and
// immediate words, steps decode/execute/writeback and owns the PC.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] n_imm,
    output logic              rd_wen,
    output logic [2:0]        rd_addr,
    output logic              halted,
    output logic              illegal,
    output logic [DATA_W-1:0] retired
);

    seq_state_t        state, state_n;
    logic [DATA_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] instr_n, imm_n, retired_n;
    logic              retire;
    logic              needs_imm, writes_rd, is_halt, is_illegal;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + DATA_W'(1);
    endfunction

    alu_seq_decode u_decode (
        .opcode     (opcode_of(instruction)),
        .needs_imm  (needs_imm),
        .writes_rd  (writes_rd),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign mem_addr  = pc;
    assign rd_addr   = instruction[RD_MSB:RD_LSB];
    assign retired_n = retire ? sat_inc(retired) : retired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_HALT;
            pc          <= RESET_PC;
            instruction <= '0;
            n_imm       <= '0;
            retired     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instruction <= instr_n;
            n_imm       <= imm_n;
            retired     <= retired_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instruction;
        imm_n   = n_imm;
        retire  = 1'b0;
        mem_req = 1'b0;
        rd_wen  = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        case (state)
            ST_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_n    = RESET_PC;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    instr_n = mem_rdata;
                    pc_n    = pc + DATA_W'(1);
                    state_n = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_halt) begin
                    retire  = 1'b1;
                    state_n = ST_HALT;
                end else if (writes_rd) begin
                    state_n = needs_imm ? ST_FETCH_N : ST_EXEC;
                end else begin
                    // NOP and undefined opcodes both retire without a write
                    retire  = 1'b1;
                    illegal = is_illegal;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH_N: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    imm_n   = mem_rdata;
                    pc_n    = pc + DATA_W'(1);
                    state_n = ST_EXEC;
                end
            end
            ST_EXEC: state_n = ST_WB;
            ST_WB: begin
                rd_wen  = 1'b1;
                retire  = 1'b1;
                state_n = ST_FETCH;
            end
            default: state_n = ST_HALT;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, hand-written reset/wrap
// sequences and random programs checked against a program-level model.
module tb_alu_sequencer;

    localparam int MAXC = 600;

    logic        clk = 1'b0;
    logic        reset_n, start, mem_ready;
    logic [15:0] mem_rdata, mem_addr, instruction, n_imm, retired;
    logic        mem_req, rd_wen, halted, illegal;
    logic [2:0]  rd_addr;

    logic        w_start, w_ready;
    logic [15:0] w_rdata, w_mem_addr, w_instr, w_nimm, w_retired;
    logic        w_mem_req, w_rd_wen, w_halted, w_illegal;
    logic [2:0]  w_rd_addr;

    logic [15:0] mem [0:65535];

    assign mem_rdata = mem[mem_addr];
    assign w_rdata   = mem[w_mem_addr];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .instruction(instruction), .n_imm(n_imm),
        .rd_wen(rd_wen), .rd_addr(rd_addr),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    alu_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .start(w_start),
        .mem_rdata(w_rdata), .mem_ready(w_ready),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .instruction(w_instr), .n_imm(w_nimm),
        .rd_wen(w_rd_wen), .rd_addr(w_rd_addr),
        .halted(w_halted), .illegal(w_illegal), .retired(w_retired)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        w_start   = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 128; a++) mem[a] = 16'h0000;
        mem[16'hFFFF] = 16'h0000;
    endtask

    // Program-level reference model: expected fetch addresses and writebacks
    typedef struct {
        logic [2:0]  rd;
        logic [15:0] instr;
        logic [15:0] imm;
    } wb_t;

    logic [15:0] exp_fetch_q[$];
    wb_t         exp_wb_q[$];
    int          m_ill, m_ret, m_pc, m_base;

    task automatic build_random(input int n);
        int          addr;
        logic [15:0] last_imm, w, imm;
        logic [11:0] low;
        int          kind, op;
        wb_t         e;
        addr = 0; last_imm = 16'h0;
        m_ill = 0; m_ret = 0; m_base = 0;
        exp_fetch_q.delete();
        exp_wb_q.delete();
        for (int i = 0; i <= n; i++) begin
            low  = 12'($urandom_range(0, 4095));
            kind = (i == n) ? 4 : $urandom_range(0, 3);
            case (kind)
                0: w = {4'h8, low};
                1: w = {4'h9, low};
                2: w = {4'h0, low};
                3: begin
                    op = $urandom_range(1, 12);
                    if (op > 7) op = op + 2;
                    w = {4'(op), low};
                end
                default: w = {4'hF, low};
            endcase
            mem[addr] = w;
            exp_fetch_q.push_back(16'(addr));
            addr++;
            m_ret++;
            if (kind == 1) begin
                imm = 16'($urandom);
                mem[addr] = imm;
                exp_fetch_q.push_back(16'(addr));
                addr++;
                last_imm = imm;
            end
            if (kind <= 1) begin
                e.rd = w[10:8]; e.instr = w; e.imm = last_imm;
                exp_wb_q.push_back(e);
            end
            m_base += (kind == 0) ? 4 : (kind == 1) ? 5 : 2;
            if (kind == 3) m_ill++;
        end
        m_pc = addr;
    endtask

    // Run results
    int          r_halt_cyc, r_ill, r_stalls, r_wen_cnt, r_wen_cyc;
    logic [2:0]  r_rd;
    logic [15:0] r_instr, r_nimm, r_addr_after, r_ret_after;

    task automatic run_prog(input int wait_n, input bit use_model);
        int  wcnt;
        bit  done;
        wb_t e;
        wcnt = 0; done = 1'b0;
        r_halt_cyc = 0; r_ill = 0; r_stalls = 0; r_wen_cnt = 0; r_wen_cyc = 0;
        r_rd = '0; r_instr = '0; r_nimm = '0; r_addr_after = '0; r_ret_after = '0;
        start = 1'b1;
        for (int cyc = 1; cyc <= MAXC && !done; cyc++) begin
            tick();
            // a second start mid-run must be ignored
            start = (cyc == 2);
            if (rd_wen) begin
                r_wen_cnt++;
                if (r_wen_cnt == 1) begin
                    r_wen_cyc = cyc; r_rd = rd_addr; r_instr = instruction; r_nimm = n_imm;
                end
                if (use_model) begin
                    if (exp_wb_q.size() == 0) begin
                        check("extra_wen", 1, 0);
                    end else begin
                        e = exp_wb_q.pop_front();
                        check("wb_rd_addr", rd_addr, e.rd);
                        check("wb_instruction", instruction, e.instr);
                        check("wb_n_imm", n_imm, e.imm);
                    end
                end
            end
            if (r_wen_cnt > 0 && cyc == r_wen_cyc + 1) begin
                r_addr_after = mem_addr; r_ret_after = retired;
            end
            if (illegal) r_ill++;
            if (halted) begin
                r_halt_cyc = cyc;
                done = 1'b1;
            end else begin
                if (mem_req)
                    mem_ready = (wait_n < 0) ? ($urandom_range(0, 2) != 0) : (wcnt >= wait_n);
                else
                    mem_ready = 1'($urandom_range(0, 1));
                if (mem_req && mem_ready) begin
                    wcnt = 0;
                    if (use_model) begin
                        if (exp_fetch_q.size() == 0) check("extra_fetch", 1, 0);
                        else check("fetch_addr", mem_addr, exp_fetch_q.pop_front());
                    end
                end else if (mem_req) begin
                    wcnt++;
                    r_stalls++;
                end
            end
        end
        start = 1'b0;
        if (!done) check("halt_timeout", 0, 1);
    endtask

    typedef struct {
        logic [15:0] w0, w1, w2;
        int          wait_n;
        int          wen_cyc;
        logic [2:0]  rd;
        logic [15:0] instr, nimm, addr_after, ret_after;
        int          ill;
        logic [15:0] ret, pc;
        int          halt_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] hold_addr, hold_ret;

        // w0 w1 w2 wait | wen_cyc rd instr nimm addr_after ret_after | ill ret pc halt_cyc
        vecs[0] = '{16'h8300, 16'hF000, 16'h0000, 0, 4, 3'd3, 16'h8300, 16'h0000, 16'h1, 16'h1, 0, 16'h2, 16'h2, 7};
        vecs[1] = '{16'h9A00, 16'h1234, 16'hF000, 2, 9, 3'd2, 16'h9A00, 16'h1234, 16'h2, 16'h1, 0, 16'h2, 16'h3, 14};
        vecs[2] = '{16'h3000, 16'hF000, 16'h0000, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 16'h2, 16'h2, 5};
        vecs[3] = '{16'h0000, 16'hF000, 16'h0000, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h2, 16'h2, 5};
        vecs[4] = '{16'h8300, 16'hF000, 16'h0000, 1, 5, 3'd3, 16'h8300, 16'h0000, 16'h1, 16'h1, 0, 16'h2, 16'h2, 9};
        vecs[5] = '{16'h9500, 16'hABCD, 16'hF000, 0, 5, 3'd5, 16'h9500, 16'hABCD, 16'h2, 16'h1, 0, 16'h2, 16'h3, 8};
        vecs[6] = '{16'hF000, 16'h0000, 16'h0000, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h1, 16'h1, 3};
        vecs[7] = '{16'hE123, 16'hF000, 16'h0000, 1, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 16'h2, 16'h2, 7};

        w_ready = 1'b1;
        clear_mem();
        do_reset();

        // Reset state, then reset while a fetch is outstanding
        check("rst_halted", halted, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_pc", mem_addr, 16'h0);
        check("rst_retired", retired, 0);
        check("rst_instruction", instruction, 0);
        check("rst_n_imm", n_imm, 0);
        check("rst_rd_wen", rd_wen, 0);
        check("rst_illegal", illegal, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_mem_req", mem_req, 1);
        check("start_mem_addr", mem_addr, 16'h0);
        tick();
        check("stall_mem_req", mem_req, 1);
        check("stall_mem_addr", mem_addr, 16'h0);
        #2 reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_halted", halted, 1);
        check("async_rst_pc", mem_addr, 16'h0);
        check("async_rst_retired", retired, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("ignored_resp_halted", halted, 1);
        check("ignored_resp_instruction", instruction, 0);
        mem_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_mem_req", mem_req, 1);
        check("restart_mem_addr", mem_addr, 16'h0);

        // Directed vector table
        foreach (vecs[i]) begin
            clear_mem();
            mem[0] = vecs[i].w0; mem[1] = vecs[i].w1; mem[2] = vecs[i].w2;
            do_reset();
            run_prog(vecs[i].wait_n, 1'b0);
            check($sformatf("v%0d_halt_cycle", i), r_halt_cyc, vecs[i].halt_cyc);
            check($sformatf("v%0d_wen_count", i), r_wen_cnt, (vecs[i].wen_cyc != 0) ? 1 : 0);
            check($sformatf("v%0d_illegal_count", i), r_ill, vecs[i].ill);
            check($sformatf("v%0d_retired", i), retired, vecs[i].ret);
            check($sformatf("v%0d_pc", i), mem_addr, vecs[i].pc);
            if (vecs[i].wen_cyc != 0) begin
                check($sformatf("v%0d_wen_cycle", i), r_wen_cyc, vecs[i].wen_cyc);
                check($sformatf("v%0d_rd_addr", i), r_rd, vecs[i].rd);
                check($sformatf("v%0d_wb_instruction", i), r_instr, vecs[i].instr);
                check($sformatf("v%0d_wb_n_imm", i), r_nimm, vecs[i].nimm);
                check($sformatf("v%0d_addr_after_wb", i), r_addr_after, vecs[i].addr_after);
                check($sformatf("v%0d_retired_after_wb", i), r_ret_after, vecs[i].ret_after);
            end
            // spurious mem_ready while halted changes nothing
            hold_addr = mem_addr; hold_ret = retired;
            mem_ready = 1'b1;
            tick();
            tick();
            mem_ready = 1'b0;
            check($sformatf("v%0d_halt_hold_pc", i), mem_addr, hold_addr);
            check($sformatf("v%0d_halt_hold_retired", i), retired, hold_ret);
            check($sformatf("v%0d_halt_hold_halted", i), halted, 1);
        end

        // Random programs against the model
        for (int p = 0; p < 4; p++) begin
            clear_mem();
            build_random(15);
            do_reset();
            run_prog(-1, 1'b1);
            check($sformatf("rnd%0d_halt_cycle", p), r_halt_cyc, m_base + r_stalls + 1);
            check($sformatf("rnd%0d_illegal_count", p), r_ill, m_ill);
            check($sformatf("rnd%0d_retired", p), retired, m_ret);
            check($sformatf("rnd%0d_pc", p), mem_addr, m_pc);
            check($sformatf("rnd%0d_fetch_left", p), exp_fetch_q.size(), 0);
            check($sformatf("rnd%0d_wb_left", p), exp_wb_q.size(), 0);
        end

        // PC wrap on the RESET_PC=FFFF instance
        clear_mem();
        mem[16'hFFFF] = 16'h0000;
        mem[0]        = 16'hF000;
        do_reset();
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        check("wrap_first_req", w_mem_req, 1);
        check("wrap_first_addr", w_mem_addr, 16'hFFFF);
        tick();
        tick();
        check("wrap_second_req", w_mem_req, 1);
        check("wrap_second_addr", w_mem_addr, 16'h0000);
        tick();
        tick();
        check("wrap_halted", w_halted, 1);
        check("wrap_pc", w_mem_addr, 16'h0001);
        check("wrap_retired", w_retired, 16'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control unit that sequences the 16-bit ALU datapath. It fetches instruction words from memory over a ready handshake and latches the instruction register and the immediate N. It steps the ALU through decode, execute and writeback, and generates the register-file write enable. It sits between instruction memory, the register file and the ALU, and owns the program counter.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset and on start
DATA_W, 16, instruction/data/address width (only 16 is supported)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leaves HALT, reloads PC to RESET_PC
mem_rdata  in  16  instruction/immediate word from memory
mem_ready  in  1  memory has valid mem_rdata for current mem_req
mem_req  out  1  fetch request, held high until mem_ready
mem_addr  out  16  fetch address (= pc)
instruction  out  16  instruction register, drives ALU instruction input
n_imm  out  16  immediate N register, drives ALU N input
rd_wen  out  1  register-file write enable for Rd, one-cycle pulse
rd_addr  out  3  = instruction[10:8]
halted  out  1  high in HALT state
illegal  out  1  one-cycle pulse on undefined opcode
retired  out  16  count of completed instructions

Behaviour:
- Reset (async, reset_n=0) clears every register immediately:
  - state=HALT; pc=RESET_PC; instruction=0; n_imm=0; retired=0
  - mem_req, rd_wen and illegal all 0; halted=1
  - Reset during a fetch drops mem_req at once. The outstanding memory response is ignored.
- Decode uses opcode=instruction[15:12] and type=instruction[11].
  - 4'h8 ADD (R-type): Rd = Rs + Rm
  - 4'h9 ADDI (I-type): Rd = Rs + N. N is the next word in memory.
  - 4'h0 NOP
  - 4'hF HLT
  - Any other opcode is illegal and executes as NOP with an illegal pulse.
- States are HALT, FETCH, DECODE, FETCH_N, EXEC and WB. Each transition takes one clock edge.
- HALT:
  - halted=1, mem_req=0.
  - start=1 -> pc=RESET_PC, go to FETCH. Otherwise stay.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On mem_ready=1: instruction<=mem_rdata, pc<=pc+1, go to DECODE.
  - Otherwise hold; mem_req stays high and mem_addr stays stable.
- DECODE:
  - ADDI -> FETCH_N.
  - ADD -> EXEC.
  - NOP or illegal -> FETCH; illegal pulses this cycle; retired+1.
  - HLT -> HALT; retired+1.
- FETCH_N:
  - Same handshake as FETCH.
  - On mem_ready=1: n_imm<=mem_rdata, pc<=pc+1, go to EXEC.
- EXEC:
  - One cycle for ALU output to settle. instruction and n_imm are held stable.
  - Go to WB.
- WB:
  - rd_wen=1 for exactly this cycle; rd_addr valid.
  - retired+1, go to FETCH.
- mem_ready is ignored whenever mem_req=0.
- start is ignored outside HALT.
- Arithmetic and wrap rules:
  - pc wraps 16'hFFFF -> 16'h0000 with no flag.
  - retired saturates at 16'hFFFF.
  - The ALU result is modulo 2^16 (the ALU's own behaviour); the sequencer does no arithmetic on data.
- Latency with zero-wait memory (mem_ready high in the first FETCH cycle):
  - ADD: 4 cycles, FETCH to WB.
  - ADDI: 5 cycles.
  - NOP/illegal/HLT: 2 cycles.
  - Each memory wait cycle adds 1.
- All outputs are registered except the following, which are combinational on state:
  - mem_req, mem_addr, rd_wen, halted, illegal
  - rd_addr (combinational on instruction)

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_NOP=4'h0, OP_ADD=4'h8, OP_ADDI=4'h9, OP_HLT=4'hF
  - state enum seq_state_t
  - instruction field slice positions, which the ALU and register file also use
- Optional sub-module alu_seq_decode, purely combinational: maps the instruction to needs_imm, writes_rd, is_halt and is_illegal. The FSM, PC and counters remain in alu_sequencer.

Test Plan:
- Reset and start:
  - Stimulus: assert reset_n=0 mid-FETCH with mem_req=1.
  - Required: mem_req=0 immediately; halted=1, pc=0, retired=0.
  - Then pulse start: mem_req=1 next cycle with mem_addr=0.
- ADD with zero wait:
  - Stimulus: mem[0]=16'h8300, mem_ready tied high.
  - Required: rd_wen pulses exactly one cycle, 4 cycles after start, with rd_addr=3; then mem_addr=1 and retired=1.
- ADDI with memory stalls:
  - Stimulus: mem[0]=16'h9A00, mem[1]=16'h1234, mem_ready low for 2 cycles on each fetch.
  - Required: n_imm=16'h1234 and instruction=16'h9A00 held through EXEC/WB; rd_addr=2; rd_wen 9 cycles after start; pc=2.
- Illegal and halt:
  - Stimulus: mem[0]=16'h3000, mem[1]=16'hF000.
  - Required: illegal pulses once with no rd_wen; halted=1 after mem[1] decodes; retired=2; start ignored during run.
- PC wrap:
  - Stimulus: RESET_PC=16'hFFFF, mem[FFFF]=NOP, mem[0]=HLT.
  - Required: mem_addr goes FFFF then 0000; halted with pc=1.
- mem_ready spurious: pulse mem_ready while in HALT/EXEC -> no state, pc or register change.
